pram_loader: RTL and testbench

Streaming writer for the 64K×8 pattern RAM that holds the sine/modulation table. It accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive RAM addresses from a programmable base. It tracks count and checksum, and reports completion. It sits between the host byte link (UART/SPI receiver) and the write port of the pattern RAM, so tables can be replaced at run time instead of only at elaboration.

---
 rtl/pram_pkg.sv | 22 ++
 rtl/pram_loader.sv | 123 ++++++++++++
 tb/tb_pram_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pram_pkg.sv
// ----------------------------------------------------------------------------
// pram_pkg
// Shared definitions for the pattern RAM subsystem (pattern RAM, its loader
// and the read-side sequencer).
//   PRAM_ADDR_W / PRAM_DATA_W / PRAM_DEPTH : geometry of the 64K x 8 table
//   PRAM_CSUM_W                            : width of the load checksum
//   pram_ld_state_e                        : loader FSM states
// ----------------------------------------------------------------------------
package pram_pkg;

    localparam int PRAM_ADDR_W = 16;
    localparam int PRAM_DATA_W = 8;
    localparam int PRAM_DEPTH  = 65536;
    localparam int PRAM_CSUM_W = 16;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_LOAD   = 2'd1,
        LD_FINISH = 2'd2
    } pram_ld_state_e;

endpackage

// File: rtl/pram_loader.sv
// ----------------------------------------------------------------------------
// pram_loader
// Streams bytes from the host byte link into the pattern RAM write port,
// starting at a programmable base address, tracking a byte count and a
// mod-2^16 checksum, and pulsing done when the requested length is written.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            begin a load (honoured only when idle)
//   abort            cancel an active load, no done pulse
//   base_addr        first RAM address, latched with start
//   length           byte count 0..2^ADDR_W, latched with start
//   s_data/s_valid   incoming byte stream
//   s_ready          loader takes a byte this cycle
//   wr_en/wr_addr/wr_data  registered RAM write port
//   busy             load in progress (LOAD or FINISH)
//   done             one-cycle completion pulse
//   checksum         sum of accepted bytes mod 2^16
//   byte_count       bytes accepted in the current or last load
// ----------------------------------------------------------------------------
module pram_loader
    import pram_pkg::*;
#(
    parameter int ADDR_W = PRAM_ADDR_W,
    parameter int DATA_W = PRAM_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W:0]        length,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [PRAM_CSUM_W-1:0] checksum,
    output logic [ADDR_W:0]        byte_count
);

    localparam logic [1:0] IDLE   = LD_IDLE;
    localparam logic [1:0] LOAD   = LD_LOAD;
    localparam logic [1:0] FINISH = LD_FINISH;

    // Checksum accumulates the zero-extended byte and simply wraps.
    function automatic logic [PRAM_CSUM_W-1:0] csum_add(
        input logic [PRAM_CSUM_W-1:0] sum,
        input logic [DATA_W-1:0]      b
    );
        return sum + PRAM_CSUM_W'(b);
    endfunction

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic              hs_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;

    // s_ready depends on state only, so the source never sees a
    // combinational path back from s_valid.
    assign s_ready = (state == LOAD);
    assign busy    = (state == LOAD) || (state == FINISH);
    assign done    = (state == FINISH);
    assign hs_p0   = s_valid && s_ready;

    assign wr_en   = vld_p1;
    assign wr_addr = addr_p1;
    assign wr_data = data_p1;

    // ---- stage p0 -> p1: accept byte, register RAM write, update counters ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            remaining  <= '0;
            vld_p1     <= 1'b0;
            addr_p1    <= '0;
            data_p1    <= '0;
            checksum   <= '0;
            byte_count <= '0;
        end else begin
            vld_p1 <= hs_p0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr        <= base_addr;
                        remaining  <= length;
                        checksum   <= '0;
                        byte_count <= '0;
                        state      <= (length == '0) ? FINISH : LOAD;
                    end
                end
                LOAD: begin
                    if (hs_p0) begin
                        addr_p1    <= ptr;
                        data_p1    <= s_data;
                        ptr        <= ptr + ADDR_W'(1);   // wraps mod 2^ADDR_W
                        remaining  <= remaining - (ADDR_W+1)'(1);
                        checksum   <= csum_add(checksum, s_data);
                        byte_count <= byte_count + (ADDR_W+1)'(1);
                    end
                    // A byte taken on the abort cycle is still written;
                    // abort only suppresses the done pulse.
                    if (abort) begin
                        state <= IDLE;
                    end else if (hs_p0 && remaining == (ADDR_W+1)'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pram_loader.sv
// ----------------------------------------------------------------------------
// tb_pram_loader
// Self-checking bench for pram_loader. A monitor records every RAM write and
// every done pulse; each scenario task drives a load and compares what the
// monitor saw with a reference computed from the byte list it sent
// (address = base + i mod 2^16, checksum = sum of bytes mod 2^16).
// ----------------------------------------------------------------------------
module tb_pram_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic [16:0] length;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic [16:0] byte_count;

    pram_loader #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .checksum(checksum), .byte_count(byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Edge counter and monitor (sampled on the falling edge).
    int          cyc = 0;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    int          done_n = 0;
    int          done_c = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_n = done_n + 1;
            done_c = cyc;
        end
    end

    logic [7:0] src[$];     // bytes to send in the next load
    int         hs_q[$];    // edge numbers at which the bench saw a handshake
    bit         pat[6];

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one load. stop_at >= 0 ends the load early at that byte index:
    // stop_kind 0 = abort with s_valid low, 1 = abort together with a byte,
    // 2 = reset. spa >= 0 pulses start (random base/length) on that iteration.
    // Returns #1 after the edge of the last handshake (or the stop edge).
    task automatic run_load(input logic [15:0] b, input logic [16:0] n, input int mode,
                            input int stop_at, input int stop_kind, input int spa,
                            output int fe, output int le, output bit to);
        int  idx;
        int  k;
        int  budget;
        bit  v;
        bit  hs;
        idx = 0; k = 0; fe = -1; le = -1; to = 1'b0;
        budget = int'(n) * 4 + 20;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = n;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 16'($urandom); length = 17'($urandom);
        while (idx < int'(n)) begin
            if (k > budget) begin
                to = 1'b1;
                break;
            end
            if (idx == stop_at) begin
                if (stop_kind == 2) begin
                    reset = 1'b1; s_valid = 1'b0;
                end else begin
                    abort = 1'b1; s_valid = (stop_kind == 1); s_data = src[idx];
                end
                hs = (stop_kind == 1) && (s_ready === 1'b1);
                @(posedge clk); #1;
                if (hs) begin
                    hs_q.push_back(cyc); le = cyc; idx++;
                end
                abort = 1'b0; reset = 1'b0; s_valid = 1'b0;
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 9) < 6);
                default: v = pat[k % 6];
            endcase
            start   = (k == spa);
            s_valid = v;
            s_data  = v ? src[idx] : 8'($urandom);
            hs      = v && (s_ready === 1'b1);
            @(posedge clk); #1;
            if (hs) begin
                if (fe < 0) fe = cyc;
                le = cyc;
                hs_q.push_back(cyc);
                idx++;
            end
            k++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; length = 17'd5;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        total++; if ({s_ready, wr_en, busy, done} !== 4'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 0000", {s_ready, wr_en, busy, done}); end
        total++; if ({wr_addr, wr_data} !== 24'h0) begin bad++; $display("FAIL reset_wr: got addr=%h data=%h want 0", wr_addr, wr_data); end
        total++; if ({checksum, byte_count} !== 33'h0) begin bad++; $display("FAIL reset_cnt: got csum=%h cnt=%0d want 0", checksum, byte_count); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    endtask

    // Complete load of src starting at b; checks writes, timing and totals.
    task automatic test_stream(input string name, input logic [15:0] b, input int mode, input int spa);
        int n, w0, d0, h0, fe, le, errs, sum;
        bit to;
        n = src.size(); w0 = wa.size(); d0 = done_n; h0 = hs_q.size(); sum = 0;
        foreach (src[i]) sum += int'(src[i]);
        run_load(b, 17'(n), mode, -1, 0, spa, fe, le, to);
        total++; if (to) begin bad++; $display("FAIL %s_timeout: accepted %0d bytes want %0d", name, hs_q.size() - h0, n); end
        total++; if ({done, wr_en, busy, s_ready} !== 4'b1110) begin bad++; $display("FAIL %s_last: done/wr_en/busy/s_ready=%b want 1110", name, {done, wr_en, busy, s_ready}); end
        total++; if (checksum !== 16'(sum)) begin bad++; $display("FAIL %s_csum: got %h want %h", name, checksum, 16'(sum)); end
        total++; if (byte_count !== 17'(n)) begin bad++; $display("FAIL %s_count: got %0d want %0d", name, byte_count, n); end
        @(posedge clk); #1;
        total++; if ({done, busy, s_ready, wr_en} !== 4'b0) begin bad++; $display("FAIL %s_after: done/busy/s_ready/wr_en=%b want 0000", name, {done, busy, s_ready, wr_en}); end
        total++; if (wa.size() - w0 != n) begin bad++; $display("FAIL %s_nwrites: got %0d want %0d", name, wa.size() - w0, n); end
        errs = 0;
        for (int i = 0; i < n && (w0 + i) < wa.size() && (h0 + i) < hs_q.size(); i++) begin
            if (wa[w0+i] !== 16'(int'(b) + i)) errs++;
            if (wd[w0+i] !== src[i]) errs++;
            if (wc[w0+i] != hs_q[h0+i]) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL %s_writes: %0d address/data/timing errors want 0", name, errs); end
        total++; if (done_n - d0 != 1 || done_c != le) begin bad++; $display("FAIL %s_done: pulses=%0d at %0d want 1 at %0d", name, done_n - d0, done_c, le); end
        if (mode == 0) begin
            total++; if (le - fe != n - 1) begin bad++; $display("FAIL %s_bubbles: span=%0d want %0d", name, le - fe, n - 1); end
        end
    endtask

    task automatic test_basic();
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        test_stream("basic", 16'h0010, 0, -1);
    endtask

    task automatic test_wrap();
        src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        test_stream("wrap", 16'hFFFE, 0, -1);
    endtask

    task automatic test_throttle();
        src = '{8'h5A, 8'hC3, 8'h7E};
        test_stream("throttle", 16'h1234, 2, -1);
    endtask

    task automatic test_back_to_back_busy_start();
        src.delete();
        for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
        test_stream("busy_start", 16'h0200, 0, 2);
    endtask

    task automatic test_zero_length();
        int w0, d0, fe, le;
        bit to;
        w0 = wa.size(); d0 = done_n;
        run_load(16'h4000, 17'd0, 0, -1, 0, -1, fe, le, to);
        total++; if ({done, busy, wr_en, s_ready} !== 4'b1100) begin bad++; $display("FAIL zero_T1: done/busy/wr_en/s_ready=%b want 1100", {done, busy, wr_en, s_ready}); end
        total++; if ({checksum, byte_count} !== 33'h0) begin bad++; $display("FAIL zero_cnt: csum=%h cnt=%0d want 0", checksum, byte_count); end
        @(posedge clk); #1;
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL zero_T2: done/busy=%b want 00", {done, busy}); end
        total++; if (wa.size() != w0 || done_n - d0 != 1) begin bad++; $display("FAIL zero_events: writes=%0d dones=%0d want 0 and 1", wa.size() - w0, done_n - d0); end
    endtask

    task automatic test_abort();
        int w0, d0, fe, le, sum;
        bit to;
        src.delete();
        for (int i = 0; i < 10; i++) src.push_back(8'($urandom));
        // abort in the cycle after the 2nd handshake
        w0 = wa.size(); d0 = done_n;
        run_load(16'h0800, 17'd10, 0, 2, 0, -1, fe, le, to);
        sum = int'(src[0]) + int'(src[1]);
        total++; if ({busy, s_ready, done} !== 3'b000) begin bad++; $display("FAIL abort_idle: busy/s_ready/done=%b want 000", {busy, s_ready, done}); end
        total++; if (byte_count !== 17'd2 || checksum !== 16'(sum)) begin bad++; $display("FAIL abort_partial: cnt=%0d csum=%h want 2 %h", byte_count, checksum, 16'(sum)); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (done_n != d0 || wa.size() - w0 != 2 || byte_count !== 17'd2) begin bad++; $display("FAIL abort_hold: dones=%0d writes=%0d cnt=%0d want 0 2 2", done_n - d0, wa.size() - w0, byte_count); end
        // abort together with the 3rd byte: that byte is still taken and written
        w0 = wa.size(); d0 = done_n;
        run_load(16'h0900, 17'd10, 0, 2, 1, -1, fe, le, to);
        sum = int'(src[0]) + int'(src[1]) + int'(src[2]);
        total++; if ({wr_en, busy, done} !== 3'b100) begin bad++; $display("FAIL abort_hs: wr_en/busy/done=%b want 100", {wr_en, busy, done}); end
        total++; if (byte_count !== 17'd3 || checksum !== 16'(sum) || wr_addr !== 16'h0902 || wr_data !== src[2]) begin bad++; $display("FAIL abort_hs_data: cnt=%0d csum=%h addr=%h data=%h want 3 %h 0902 %h", byte_count, checksum, wr_addr, wr_data, 16'(sum), src[2]); end
        // abort while idle is ignored
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || done_n != d0 || byte_count !== 17'd3) begin bad++; $display("FAIL abort_in_idle: busy=%b dones=%0d cnt=%0d want 0 0 3", busy, done_n - d0, byte_count); end
    endtask

    task automatic test_reset_midload();
        int fe, le;
        bit to;
        src.delete();
        for (int i = 0; i < 10; i++) src.push_back(8'($urandom_range(1, 255)));
        run_load(16'h3000, 17'd10, 0, 3, 2, -1, fe, le, to);
        total++; if ({s_ready, wr_en, busy, done} !== 4'b0) begin bad++; $display("FAIL rst_mid_ctrl: %b want 0000", {s_ready, wr_en, busy, done}); end
        total++; if ({wr_addr, wr_data, checksum, byte_count} !== 57'h0) begin bad++; $display("FAIL rst_mid_data: addr=%h data=%h csum=%h cnt=%0d want 0", wr_addr, wr_data, checksum, byte_count); end
        src.delete();
        for (int i = 0; i < 5; i++) src.push_back(8'($urandom));
        test_stream("after_reset", 16'h3100, 0, -1);
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 48);
            src.delete();
            for (int i = 0; i < n; i++) src.push_back(8'($urandom));
            test_stream("random", 16'($urandom), 1, -1);
        end
    endtask

    task automatic test_full_table();
        src.delete();
        for (int i = 0; i < 65536; i++) src.push_back(8'hFF);
        test_stream("full", 16'h0000, 0, -1);
    endtask

    initial begin
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0; s_data = '0; s_valid = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_throttle();
        test_back_to_back_busy_start();
        test_zero_length();
        test_abort();
        test_reset_midload();
        test_random();
        test_full_table();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
